// File: rtl/led_bar_pkg.sv
// Shared definitions for the LED bargraph arbiter.
// Provides the arbiter state encoding, the fade-ramp command encoding,
// source indices and widths, plus the two priority helpers the FSM needs.
package led_bar_pkg;

  localparam int N_SRC   = 3;
  localparam int LED_W   = 8;
  localparam int LEVEL_W = 8;
  localparam int HOLD_W  = 24;

  localparam int SRC_SCAN  = 0;
  localparam int SRC_SPEED = 1;
  localparam int SRC_ALERT = 2;

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    GRANTED,
    FADE_OUT
  } arb_state_t;

  // What the level register does this cycle (load_zero overrides all).
  typedef enum logic [1:0] {
    RAMP_HOLD,
    RAMP_UP,
    RAMP_DOWN,
    RAMP_TRACK
  } ramp_dir_t;

  // Fixed priority: alert > speed > scanner. Returns one-hot, or 0 if no request.
  function automatic logic [N_SRC-1:0] pick_winner(input logic [N_SRC-1:0] req);
    logic [N_SRC-1:0] w;
    w = '0;
    if (req[SRC_ALERT])      w[SRC_ALERT] = 1'b1;
    else if (req[SRC_SPEED]) w[SRC_SPEED] = 1'b1;
    else if (req[SRC_SCAN])  w[SRC_SCAN]  = 1'b1;
    return w;
  endfunction

  // True when any source of higher priority than the one-hot owner requests.
  // (owner<<1)-1 sets the owner bit and everything below it; its complement is
  // the set of strictly higher-priority sources. A zero owner yields no bits.
  function automatic logic has_higher(input logic [N_SRC-1:0] req,
                                      input logic [N_SRC-1:0] owner);
    logic [N_SRC-1:0] above;
    above = ~(N_SRC'(owner << 1) - N_SRC'(1));
    return |(req & above);
  endfunction

endpackage

// File: rtl/led_bar_arbiter_if.sv
// Bus between the pattern sources and the LED bargraph arbiter.
//   req            : per-source level-sensitive request
//   mask0..mask2   : per-source LED on/off pattern
//   level0..level2 : per-source target brightness
//   grant          : one-hot current owner, 0 when idle
//   led_mask       : registered mask of the owner
//   led_level      : registered brightness to the PWM stage
//   switching      : high while fading in or out
// master = pattern-source side, slave = arbiter side.
interface led_bar_arbiter_if;
  import led_bar_pkg::*;

  logic [N_SRC-1:0]   req;
  logic [LED_W-1:0]   mask0;
  logic [LED_W-1:0]   mask1;
  logic [LED_W-1:0]   mask2;
  logic [LEVEL_W-1:0] level0;
  logic [LEVEL_W-1:0] level1;
  logic [LEVEL_W-1:0] level2;
  logic [N_SRC-1:0]   grant;
  logic [LED_W-1:0]   led_mask;
  logic [LEVEL_W-1:0] led_level;
  logic               switching;

  modport master (
    output req, mask0, mask1, mask2, level0, level1, level2,
    input  grant, led_mask, led_level, switching
  );

  modport slave (
    input  req, mask0, mask1, mask2, level0, level1, level2,
    output grant, led_mask, led_level, switching
  );

endinterface

// File: rtl/led_fade_ramp.sv
// Brightness ramp for the bargraph arbiter.
// Holds the free-running fade prescaler and the saturating level register.
//   clk, rst  : clock, synchronous active-high reset
//   dir       : hold / step up / step down / track target
//   target    : brightness the ramp moves toward (and tracks)
//   load_zero : force level to 0 on the next edge (overrides dir)
//   level     : registered brightness
//   at_target : level >= target
//   at_zero   : level == 0
module led_fade_ramp
  import led_bar_pkg::*;
#(
  parameter int                 TICK_BITS = 16,
  parameter logic [LEVEL_W-1:0] FADE_STEP = 8'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  ramp_dir_t          dir,
  input  logic [LEVEL_W-1:0] target,
  input  logic               load_zero,
  output logic [LEVEL_W-1:0] level,
  output logic               at_target,
  output logic               at_zero
);

  logic [TICK_BITS-1:0] presc;
  logic                 fade_tick;
  logic [LEVEL_W-1:0]   level_nxt;

  // Step up by FADE_STEP in 9 bits, saturate at full scale, then clip at target.
  function automatic logic [LEVEL_W-1:0] step_up(input logic [LEVEL_W-1:0] cur,
                                                 input logic [LEVEL_W-1:0] tgt);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, cur} + {1'b0, FADE_STEP};
    if (sum > {1'b0, {LEVEL_W{1'b1}}}) sum = {1'b0, {LEVEL_W{1'b1}}};
    if (sum > {1'b0, tgt})             sum = {1'b0, tgt};
    return sum[LEVEL_W-1:0];
  endfunction

  // Step down by FADE_STEP with a signed 9-bit difference, floored at zero.
  function automatic logic [LEVEL_W-1:0] step_down(input logic [LEVEL_W-1:0] cur);
    logic signed [LEVEL_W:0] diff;
    diff = $signed({1'b0, cur}) - $signed({1'b0, FADE_STEP});
    if (diff < 0) return '0;
    return diff[LEVEL_W-1:0];
  endfunction

  // Prescaler: one fade tick on the all-ones count, then natural wrap to 0.
  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= presc + TICK_BITS'(1);
  end

  assign fade_tick = &presc;

  always_comb begin
    level_nxt = level;
    if (load_zero) begin
      level_nxt = '0;
    end else begin
      unique case (dir)
        RAMP_UP:    if (fade_tick) level_nxt = step_up(level, target);
        RAMP_DOWN:  if (fade_tick) level_nxt = step_down(level);
        RAMP_TRACK: level_nxt = target;
        default:    level_nxt = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= level_nxt;
  end

  assign at_target = (level >= target);
  assign at_zero   = (level == '0);

endmodule

// File: rtl/led_bar_arbiter.sv
// Shares the 8-LED PWM bargraph between three pattern sources
// (scanner, speed feedback, alert) with fixed priority, a minimum hold time
// before preemption, and a linear fade out/in on every handover.
//   clk, rst : clock, synchronous active-high reset
//   bus      : led_bar_arbiter_if slave side (requests, masks, levels in;
//              grant, led_mask, led_level, switching out)
module led_bar_arbiter
  import led_bar_pkg::*;
#(
  parameter int                 TICK_BITS   = 16,
  parameter logic [LEVEL_W-1:0] FADE_STEP   = 8'd16,
  parameter logic [HOLD_W-1:0]  HOLD_CYCLES = 24'd1000000
) (
  input  logic               clk,
  input  logic               rst,
  led_bar_arbiter_if.slave   bus
);

  if (FADE_STEP == '0) begin : g_bad_fade_step
    $error("led_bar_arbiter: FADE_STEP must be non-zero or a fade never ends");
  end

  arb_state_t         state, state_nxt;
  logic [N_SRC-1:0]   grant, grant_nxt;
  logic [HOLD_W-1:0]  hold, hold_nxt;
  logic [LED_W-1:0]   led_mask, led_mask_nxt;
  ramp_dir_t          dir;
  logic               load_zero;
  logic [LEVEL_W-1:0] target;
  logic [LEVEL_W-1:0] level;
  logic               at_target;
  logic               at_zero;
  logic               owner_req;
  logic               higher_req;

  led_fade_ramp #(
    .TICK_BITS (TICK_BITS),
    .FADE_STEP (FADE_STEP)
  ) u_ramp (
    .clk       (clk),
    .rst       (rst),
    .dir       (dir),
    .target    (target),
    .load_zero (load_zero),
    .level     (level),
    .at_target (at_target),
    .at_zero   (at_zero)
  );

  // Target brightness of the current owner, taken live from its input.
  always_comb begin
    target = '0;
    if (grant[SRC_SCAN])  target = target | bus.level0;
    if (grant[SRC_SPEED]) target = target | bus.level1;
    if (grant[SRC_ALERT]) target = target | bus.level2;
  end

  assign owner_req  = |(bus.req & grant);
  assign higher_req = has_higher(bus.req, grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      hold     <= '0;
      led_mask <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      hold     <= hold_nxt;
      led_mask <= led_mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    hold_nxt  = hold;
    dir       = RAMP_HOLD;
    load_zero = 1'b0;
    unique case (state)
      IDLE: begin
        load_zero = 1'b1;
        grant_nxt = '0;
        if (|bus.req) begin
          grant_nxt = pick_winner(bus.req);
          state_nxt = FADE_IN;
        end
      end
      FADE_IN: begin
        // An owner that leaves mid-fade-in fades out from wherever it got to.
        if (!owner_req) begin
          state_nxt = FADE_OUT;
        end else if (at_target) begin
          // Covers both reaching the target and the target dropping below us.
          dir       = RAMP_TRACK;
          hold_nxt  = HOLD_CYCLES;
          state_nxt = GRANTED;
        end else begin
          dir = RAMP_UP;
        end
      end
      GRANTED: begin
        dir = RAMP_TRACK;
        if (hold != '0) hold_nxt = hold - HOLD_W'(1);
        if (!owner_req)                      state_nxt = FADE_OUT;
        else if (hold == '0 && higher_req)   state_nxt = FADE_OUT;
      end
      FADE_OUT: begin
        // Owner is kept until the bar is dark, so the old mask never shows
        // the new source's brightness and vice versa.
        if (at_zero) begin
          load_zero = 1'b1;
          if (|bus.req) begin
            grant_nxt = pick_winner(bus.req);
            state_nxt = FADE_IN;
          end else begin
            grant_nxt = '0;
            state_nxt = IDLE;
          end
        end else begin
          dir = RAMP_DOWN;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        load_zero = 1'b1;
      end
    endcase
  end

  // Mask follows the owner that grant will hold after this edge, so mask and
  // grant change on the same cycle and the mask is 0 whenever grant is 0.
  always_comb begin
    led_mask_nxt = '0;
    if (grant_nxt[SRC_SCAN])  led_mask_nxt = led_mask_nxt | bus.mask0;
    if (grant_nxt[SRC_SPEED]) led_mask_nxt = led_mask_nxt | bus.mask1;
    if (grant_nxt[SRC_ALERT]) led_mask_nxt = led_mask_nxt | bus.mask2;
  end

  assign bus.grant     = grant;
  assign bus.led_mask  = led_mask;
  assign bus.led_level = level;
  assign bus.switching = (state == FADE_IN) || (state == FADE_OUT);

endmodule
